// File: rtl/pasc_io_pkg.sv
// Shared definitions for the core-side remote I/O ports: register map
// defaults and the layout of the STATUS register.
package pasc_io_pkg;

  localparam logic [15:0] IO_BASE_DEFAULT = 16'hFFF0;
  localparam logic [15:0] DATA_OFFSET     = 16'd0;
  localparam logic [15:0] STATUS_OFFSET   = 16'd1;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_COUNT_LSB = 2;
  localparam int STATUS_COUNT_MSB = 8;

  // Field order matches the bit positions above (MSB first).
  typedef struct packed {
    logic [6:0] zero;
    logic [6:0] count;
    logic       full;
    logic       empty;
  } status_t;

  function automatic status_t make_status(input logic empty, input logic full,
                                          input logic [6:0] count);
    status_t s;
    s.zero  = '0;
    s.count = count;
    s.full  = full;
    s.empty = empty;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word, so the consumer sees a
// flop output rather than a memory read path.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_next;

  assign rd_next = rd_ptr + 1'b1;
  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_next;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // The next head comes from the incoming word when it lands in a FIFO
      // that is (or becomes) otherwise empty, else from the slot behind it.
      if (push && (empty || (pop && count == CW'(1))))
        head <= push_data;
      else if (pop && count > CW'(1))
        head <= mem[rd_next];
    end
  end

endmodule

// File: rtl/remote_output_port.sv
// Memory-mapped output port: core writes to DATA are queued and streamed
// out on a valid/ready interface; STATUS exposes empty/full/count.
module remote_output_port
  import pasc_io_pkg::*;
#(
  parameter int          DEPTH   = 8,
  parameter logic [15:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        remote_wren,
  input  logic        remote_rden,
  input  logic [15:0] remote_addr,
  input  logic [15:0] remote_write_val,
  output logic [15:0] remote_read_val,
  output logic        remote_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready
);

  localparam logic [15:0] DATA_ADDR   = IO_BASE + DATA_OFFSET;
  localparam logic [15:0] STATUS_ADDR = IO_BASE + STATUS_OFFSET;

  logic                    is_data;
  logic                    is_status;
  logic                    data_write;
  logic                    push;
  logic                    pop;
  logic                    empty;
  logic                    full;
  logic [$clog2(DEPTH):0]  count;
  status_t                 status;

  assign is_data    = (remote_addr == DATA_ADDR);
  assign is_status  = (remote_addr == STATUS_ADDR);
  assign data_write = remote_wren && is_data;

  // Handshakes: a word moves on a rising edge only when its valid and ready
  // are both high in the preceding cycle. Core side: valid = DATA write,
  // ready = remote_ready (low only while FIFO is full, from the registered
  // flag, so a stalled write lands on the edge after a pop frees a slot).
  // Stream side: valid = out_valid, ready = out_ready.
  assign remote_ready = !(data_write && full);
  assign push         = data_write && !full;
  assign pop          = out_valid && out_ready;
  assign out_valid    = !empty;

  assign status          = make_status(empty, full, 7'(count));
  assign remote_read_val = is_status ? status : 16'h0000;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (remote_write_val),
    .pop       (pop),
    .head      (out_data),
    .empty     (empty),
    .full      (full),
    .count     (count)
  );

endmodule

// File: tb/tb_remote_output_port.sv
// Bench for remote_output_port: directed register-map scenarios with a
// scoreboard that follows every accepted DATA write through the stream side.
module tb_remote_output_port;

  localparam logic [15:0] DATA_A   = 16'hFFF0;
  localparam logic [15:0] STATUS_A = 16'hFFF1;

  logic        clk = 1'b0;
  logic        reset;
  logic        remote_wren;
  logic        remote_rden;
  logic [15:0] remote_addr;
  logic [15:0] remote_write_val;
  logic [15:0] remote_read_val;
  logic        remote_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;

  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  remote_output_port #(.DEPTH(8), .IO_BASE(16'hFFF0)) dut (
    .clk              (clk),
    .reset            (reset),
    .remote_wren      (remote_wren),
    .remote_rden      (remote_rden),
    .remote_addr      (remote_addr),
    .remote_write_val (remote_write_val),
    .remote_read_val  (remote_read_val),
    .remote_ready     (remote_ready),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_ready        (out_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // scoreboard: pop/compare on stream transfers, push on accepted DATA writes
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
        else check("stream_data", out_data, exp_q.pop_front());
      end
      if (remote_wren && remote_addr == DATA_A && remote_ready)
        exp_q.push_back(remote_write_val);
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves wren asserted on return (just after the accepting edge).
  task automatic write_word(input logic [15:0] addr, input logic [15:0] val);
    int n = 0;
    remote_wren      = 1'b1;
    remote_addr      = addr;
    remote_write_val = val;
    forever begin
      @(negedge clk);
      if (remote_ready || n >= 40) break;
      n++;
    end
    if (n >= 40) check("write_timeout", n, 0);
    next_cycle();
  endtask

  task automatic read_check(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    logic [15:0] saved = remote_addr;
    remote_rden = 1'b1;
    remote_addr = addr;
    #1;
    check(tag, remote_read_val, exp);
    check({tag, "_ready"}, remote_ready, 1'b1);
    remote_rden = 1'b0;
    remote_addr = saved;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (out_valid && n < 50) begin
      next_cycle();
      n++;
    end
    check("drain_done", out_valid, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    remote_wren = 1'b0;
    remote_rden = 1'b0;
    remote_addr = 16'h0000;
    remote_write_val = 16'h0000;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_ready", remote_ready, 1'b1);
    read_check("rst_status", STATUS_A, 16'h0001);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // single word pass-through
    out_ready = 1'b1;
    write_word(DATA_A, 16'h1234);
    remote_wren = 1'b0;
    check("t1_valid", out_valid, 1'b1);
    check("t1_data", out_data, 16'h1234);
    next_cycle();
    check("t1_empty_valid", out_valid, 1'b0);
    read_check("t1_status", STATUS_A, 16'h0001);

    // fill, stall, release by one pop
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) write_word(DATA_A, 16'(i));
    remote_write_val = 16'h0009;
    #1;
    check("t2_stall_ready", remote_ready, 1'b0);
    remote_wren = 1'b0;
    read_check("t2_status_full", STATUS_A, 16'h0022);
    remote_addr = DATA_A;
    remote_wren = 1'b1;
    next_cycle();
    check("t2_still_stalled", remote_ready, 1'b0);
    check("t2_head_stable", out_data, 16'h0001);
    out_ready = 1'b1;
    #1;
    check("t2_no_same_cycle", remote_ready, 1'b0);
    next_cycle();
    out_ready = 1'b0;
    check("t2_ready_after_pop", remote_ready, 1'b1);
    check("t2_new_head", out_data, 16'h0002);
    next_cycle();
    remote_wren = 1'b0;
    read_check("t2_status_refull", STATUS_A, 16'h0022);
    out_ready = 1'b1;
    wait_empty();
    read_check("t2_status_drained", STATUS_A, 16'h0001);

    // steady flow at half full, wrapping pointers
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_word(DATA_A, 16'($urandom_range(0, 16'hFFFF)));
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) write_word(DATA_A, 16'($urandom_range(0, 16'hFFFF)));
    remote_wren = 1'b0;
    out_ready = 1'b0;
    read_check("t3_status_half", STATUS_A, 16'h0010);
    out_ready = 1'b1;
    wait_empty();

    // unmapped, DATA read and STATUS write have no effect
    remote_rden = 1'b1;
    write_word(16'hFFF5, 16'hBEEF);
    remote_wren = 1'b0;
    remote_rden = 1'b0;
    read_check("t4_unmapped_read", 16'hFFF5, 16'h0000);
    check("t4_unmapped_valid", out_valid, 1'b0);
    read_check("t4_data_read", DATA_A, 16'h0000);
    write_word(STATUS_A, 16'h5555);
    remote_wren = 1'b0;
    check("t4_status_write_valid", out_valid, 1'b0);
    read_check("t4_status", STATUS_A, 16'h0001);

    // reset discards queued words
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) write_word(DATA_A, 16'h0100 + 16'(i));
    remote_wren = 1'b0;
    read_check("t5_status_3", STATUS_A, 16'h000C);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("t5_rst_valid", out_valid, 1'b0);
    check("t5_rst_data", out_data, 16'h0000);
    read_check("t5_rst_status", STATUS_A, 16'h0001);
    next_cycle();
    reset = 1'b0;
    next_cycle();
    write_word(DATA_A, 16'hABCD);
    remote_wren = 1'b0;
    check("t5_first_after_rst", out_data, 16'hABCD);
    out_ready = 1'b1;
    wait_empty();

    next_cycle();
    check("sb_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/remote_output_port.md
REMOTE_OUTPUT_PORT -- requirements
Module: remote_output_port

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; power of two, 2..64.
REQ-002 Parameter IO_BASE, default 16'hFFF0, remote address of the DATA register; STATUS register is IO_BASE+1.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 remote_wren  input  1  core remote write strobe.
REQ-006 remote_rden  input  1  core remote read strobe.
REQ-007 remote_addr  input  16  core remote address.
REQ-008 remote_write_val  input  16  core remote write data.
REQ-009 remote_read_val  output  16  read data returned to core.
REQ-010 remote_ready  output  1  transfer-complete qualifier; low stalls core.
REQ-011 out_valid  output  1  out_data holds an entry.
REQ-012 out_data  output  16  head-of-FIFO word.
REQ-013 out_ready  input  1  downstream consumer accepts head when high with out_valid.

Function
REQ-014 Block SHALL decode DATA (addr==IO_BASE) and STATUS (addr==IO_BASE+1); all other addresses ignored, remote_ready high, read value 16'h0000.
REQ-015 Push SHALL occur on a clock edge iff remote_wren, addr==DATA, and FIFO not full; word = remote_write_val.
REQ-016 remote_ready SHALL be low combinationally iff remote_wren, addr==DATA, and FIFO full; high in all other cases.
REQ-017 Stalled write SHALL complete on the first edge after a pop makes space; push and remote_ready rise together in that cycle (decision based on registered full flag, not same-cycle pop).
REQ-018 Pop SHALL occur on an edge iff out_valid and out_ready.
REQ-019 out_valid SHALL equal !empty; out_data SHALL be the registered head entry, stable while out_valid and !out_ready.
REQ-020 Push-to-out_valid latency: one cycle (word visible the cycle after the accepting edge when FIFO was empty).
REQ-021 Simultaneous push and pop with FIFO neither empty nor full: count unchanged, both accepted, FIFO order preserved.
REQ-022 Full: push rejected per REQ-016 even if pop same cycle; empty: pop impossible (out_valid low).
REQ-023 Pointers SHALL wrap modulo DEPTH; count width clog2(DEPTH)+1, range 0..DEPTH.
REQ-024 STATUS read SHALL return combinationally: bit0 empty, bit1 full, bits[8:2] count zero-extended, bits[15:9] zero; remote_ready high.
REQ-025 DATA read SHALL return 16'h0000 with remote_ready high and no side effect.
REQ-026 remote_wren and remote_rden both high: write semantics apply, read value still per address.
REQ-027 Writes to STATUS SHALL be ignored.

Reset
REQ-028 On reset assertion: read/write pointers and count 0, out_valid 0, out_data 16'h0000, remote_ready 1 (absent a full-FIFO write), remote_read_val per REQ-024/025 with empty state.
REQ-029 Reset mid-operation SHALL discard all entries and abort any stalled write without push.
REQ-030 Storage array contents need not be reset.

Structure
REQ-031 Shared package pasc_io_pkg SHALL hold IO_BASE default, register offsets (DATA=0, STATUS=1), and STATUS bit positions.
REQ-032 FIFO storage/pointers SHALL be one sub-module, sync_fifo (parameter DEPTH, WIDTH=16), instantiated once; decode/stall logic stays in remote_output_port.

Verification
REQ-033 Reset, write 16'h1234 to FFF0, out_ready=1 -> out_valid rises next cycle with out_data 1234, pops, returns to empty.
REQ-034 out_ready=0, write 9 words 0001..0009 -> first 8 accepted, 9th holds remote_ready low; STATUS read = 16'h0022; raise out_ready one cycle -> 0001 popped, 0009 accepted next edge.
REQ-035 Continuous writes with out_ready=1 at half-full -> count stays constant, output order matches input over 20 words including pointer wrap.
REQ-036 Write 16'hBEEF to FFF5 and read FFF5 -> no push, read value 0000, remote_ready high.
REQ-037 Fill 3 entries, assert reset mid-stall-free operation -> STATUS reads 16'h0001, out_valid 0; subsequent write 16'hABCD emerges first.
